// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : counter_seq_ctrl
// Description : Command-driven interval timer controller. A valid/ready port
//               accepts NOP/START/STOP/LOAD commands that sequence an internal
//               up-counter through IDLE, RUN, PAUSED and DONE. Supports
//               one-shot and auto-reload modes with a one-cycle terminal-count
//               pulse. Optional build macro PRESCALER_EN adds a prescale input
//               that gates how often the counter advances.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_mode,
`ifdef PRESCALER_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_START = 2'b01;
    localparam logic [1:0] c_OP_STOP  = 2'b10;
    localparam logic [1:0] c_OP_LOAD  = 2'b11;

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_period;
    logic             r_mode;
    logic             r_busy;
    logic             r_tc;
    logic             r_done;
    logic             r_err;
    logic             r_ready;

    logic             w_accept;
    logic             w_tick;
    logic             w_pre_clr;
    logic [1:0]       w_state;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_period;
    logic             w_mode;
    logic             w_done;
    logic             w_tc;
    logic             w_err;

    assign w_accept = cmd_valid & r_ready;

`ifdef PRESCALER_EN
    localparam logic [PRE_W-1:0] c_PRE_ONE = PRE_W'(1);
    logic [PRE_W-1:0] r_pre;

    assign w_tick = (r_pre == prescale);

    // Prescaler: steps only on RUN edges without an accepted command, wraps on match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre <= '0;
        end else if (w_pre_clr) begin
            r_pre <= '0;
        end else if ((r_state == S_RUN) && !w_accept) begin
            r_pre <= w_tick ? '0 : (r_pre + c_PRE_ONE);
        end
    end
`else
    logic [PRE_W:0] w_unused_pre;

    // Without the prescaler every RUN cycle is a counting cycle
    assign w_tick       = 1'b1;
    assign w_unused_pre = {{PRE_W{1'b0}}, w_pre_clr};
`endif

    // Next-state decode: an accepted command always pre-empts counting and terminal events
    always_comb begin
        w_state   = r_state;
        w_count   = r_count;
        w_period  = r_period;
        w_mode    = r_mode;
        w_done    = r_done;
        w_tc      = 1'b0;
        w_err     = 1'b0;
        w_pre_clr = 1'b0;
        if (w_accept) begin
            case (cmd_op)
                c_OP_LOAD: begin
                    if (r_state == S_RUN) begin
                        w_err = 1'b1;
                    end else begin
                        w_period = cmd_data;
                        if (r_state == S_DONE) begin
                            w_state = S_IDLE;
                            w_done  = 1'b0;
                            w_count = '0;
                        end
                    end
                end
                c_OP_START: begin
                    case (r_state)
                        S_RUN:    w_err   = 1'b1;
                        S_PAUSED: w_state = S_RUN;
                        default: begin
                            w_state   = S_RUN;
                            w_count   = '0;
                            w_mode    = cmd_mode;
                            w_done    = 1'b0;
                            w_pre_clr = 1'b1;
                        end
                    endcase
                end
                c_OP_STOP: begin
                    if (r_state == S_RUN) begin
                        w_state = S_PAUSED;
                    end else begin
                        w_state   = S_IDLE;
                        w_count   = '0;
                        w_done    = 1'b0;
                        w_pre_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if ((r_state == S_RUN) && w_tick) begin
            if (r_count != r_period) begin
                w_count = r_count + c_ONE;
            end else if (r_mode) begin
                w_count = '0;
                w_tc    = 1'b1;
            end else begin
                w_state = S_DONE;
                w_done  = 1'b1;
                w_tc    = 1'b1;
            end
        end
    end

    // State and output registers; ready drops for one cycle after each accepted command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_period <= '0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_tc     <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_count  <= w_count;
            r_period <= w_period;
            r_mode   <= w_mode;
            r_busy   <= (w_state == S_RUN);
            r_tc     <= w_tc;
            r_done   <= w_done;
            r_err    <= w_err;
            r_ready  <= ~w_accept;
        end
    end

    assign cmd_ready = r_ready;
    assign count     = r_count;
    assign busy      = r_busy;
    assign tc        = r_tc;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_seq_ctrl
// Description : Scoreboard bench for counter_seq_ctrl. Directed stimulus pushes
//               hand-computed expected outputs per clock; a monitor pops and
//               compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    localparam int W = 4;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = OP_NOP;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_mode = 1'b0;
    logic [W-1:0] count;
    logic         busy, tc, done, err;
`ifdef PRESCALER_EN
    logic [3:0]   prescale = 4'd0;
`endif

    int total = 0;
    int bad   = 0;

    logic [W+4:0] exp_q[$];
    string        name_q[$];

    counter_seq_ctrl #(.WIDTH(W), .PRE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_mode  (cmd_mode),
`ifdef PRESCALER_EN
        .prescale  (prescale),
`endif
        .count     (count),
        .busy      (busy),
        .tc        (tc),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Monitor: compares the DUT outputs against the oldest expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W+4:0] e;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if ({count, busy, tc, done, err, cmd_ready} !== e) begin
                bad++;
                $display("FAIL %s: got cnt=%0d busy=%b tc=%b done=%b err=%b rdy=%b, want cnt=%0d busy=%b tc=%b done=%b err=%b rdy=%b",
                         nm, count, busy, tc, done, err, cmd_ready,
                         e[W+4:5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic push(input logic [W-1:0] ec, input logic eb, input logic et,
                        input logic ed, input logic ee, input logic er, input string nm);
        exp_q.push_back({ec, eb, et, ed, ee, er});
        name_q.push_back(nm);
    endtask

    // One clock: drive inputs, clock, record what the outputs must be afterwards
    task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] d, input logic m,
                        input logic [W-1:0] ec, input logic eb, input logic et,
                        input logic ed, input logic ee, input logic er, input string nm);
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        cmd_mode  = m;
        @(posedge clk);
        #1;
        push(ec, eb, et, ed, ee, er, nm);
    endtask

    task automatic nop(input logic [W-1:0] ec, input logic eb, input logic et,
                       input logic ed, input logic ee, input logic er, input string nm);
        step(1'b0, OP_NOP, '0, 1'b0, ec, eb, et, ed, ee, er, nm);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] d, input logic m,
                       input logic [W-1:0] ec, input logic eb, input logic et,
                       input logic ed, input logic ee, input logic er, input string nm);
        step(1'b1, op, d, m, ec, eb, et, ed, ee, er, nm);
    endtask

    // Assert reset just after an edge, hold it across one more edge, then release
    task automatic rst_seq();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push('0, 0, 0, 0, 0, 0, "rst_async");
        @(posedge clk);
        #1;
        push('0, 0, 0, 0, 0, 0, "rst_held");
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] c;
        rst_seq();
        nop(0, 0, 0, 0, 0, 1, "rdy_after_rst");

        // Auto-reload, period 3
        cmd(OP_LOAD, 4'd3, 0, 0, 0, 0, 0, 0, 0, "ar_load");
        nop(0, 0, 0, 0, 0, 1, "ar_gap");
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "ar_start");
        for (int i = 1; i <= 12; i++) begin
            c = W'(i % 4);
            nop(c, 1, (c == 0), 0, 0, 1, "ar_run");
        end
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "ar_pause");
        nop(0, 0, 0, 0, 0, 1, "ar_gap2");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "ar_idle");
        nop(0, 0, 0, 0, 0, 1, "ar_gap3");

        // One-shot, period 5
        cmd(OP_LOAD, 4'd5, 0, 0, 0, 0, 0, 0, 0, "os_load");
        nop(0, 0, 0, 0, 0, 1, "os_gap");
        cmd(OP_START, 0, 0, 0, 1, 0, 0, 0, 0, "os_start");
        for (int i = 1; i <= 5; i++) nop(W'(i), 1, 0, 0, 0, 1, "os_run");
        nop(5, 0, 1, 1, 0, 1, "os_term");
        nop(5, 0, 0, 1, 0, 1, "os_hold1");
        nop(5, 0, 0, 1, 0, 1, "os_hold2");
        cmd(OP_LOAD, 4'd2, 0, 0, 0, 0, 0, 0, 0, "os_load_clear");
        nop(0, 0, 0, 0, 0, 1, "os_gap2");

        // Pause / resume, period 9, auto-reload kept across resume
        cmd(OP_LOAD, 4'd9, 0, 0, 0, 0, 0, 0, 0, "pr_load");
        nop(0, 0, 0, 0, 0, 1, "pr_gap");
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "pr_start");
        for (int i = 1; i <= 4; i++) nop(W'(i), 1, 0, 0, 0, 1, "pr_run");
        cmd(OP_STOP, 0, 0, 4, 0, 0, 0, 0, 0, "pr_pause");
        for (int i = 0; i < 10; i++) nop(4, 0, 0, 0, 0, 1, "pr_hold");
        cmd(OP_START, 0, 0, 4, 1, 0, 0, 0, 0, "pr_resume");
        for (int i = 5; i <= 9; i++) nop(W'(i), 1, 0, 0, 0, 1, "pr_run2");
        nop(0, 1, 1, 0, 0, 1, "pr_wrap");
        nop(1, 1, 0, 0, 0, 1, "pr_run3");
        nop(2, 1, 0, 0, 0, 1, "pr_run3");
        // cmd_valid held high three cycles: first and third are accepted
        cmd(OP_STOP, 0, 0, 2, 0, 0, 0, 0, 0, "b2b_1");
        cmd(OP_STOP, 0, 0, 2, 0, 0, 0, 0, 1, "b2b_2");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "b2b_3");
        nop(0, 0, 0, 0, 0, 1, "b2b_gap");

        // Illegal LOAD in RUN, then STOP colliding with the terminal count
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "il_start");
        nop(1, 1, 0, 0, 0, 1, "il_run");
        cmd(OP_LOAD, 4'd1, 0, 1, 1, 0, 0, 1, 0, "il_load_err");
        for (int i = 2; i <= 9; i++) nop(W'(i), 1, 0, 0, 0, 1, "il_period_kept");
        nop(0, 1, 1, 0, 0, 1, "il_wrap");
        for (int i = 1; i <= 9; i++) nop(W'(i), 1, 0, 0, 0, 1, "il_run2");
        cmd(OP_STOP, 0, 0, 9, 0, 0, 0, 0, 0, "stop_at_tc");
        nop(9, 0, 0, 0, 0, 1, "stop_at_tc_hold");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "il_idle");
        nop(0, 0, 0, 0, 0, 1, "il_gap");

        // Period 0: auto-reload fires every cycle, START in RUN is an error
        cmd(OP_LOAD, 4'd0, 0, 0, 0, 0, 0, 0, 0, "p0_load");
        nop(0, 0, 0, 0, 0, 1, "p0_gap");
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "p0_start");
        for (int i = 0; i < 3; i++) nop(0, 1, 1, 0, 0, 1, "p0_tc");
        cmd(OP_START, 0, 0, 0, 1, 0, 0, 1, 0, "p0_start_in_run");
        nop(0, 1, 1, 0, 0, 1, "p0_tc2");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "p0_pause");
        nop(0, 0, 0, 0, 0, 1, "p0_gap2");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "p0_idle");
        nop(0, 0, 0, 0, 0, 1, "p0_gap3");

        // Period 0 one-shot, then restart straight from DONE
        cmd(OP_START, 0, 0, 0, 1, 0, 0, 0, 0, "p0os_start");
        nop(0, 0, 1, 1, 0, 1, "p0os_done");
        nop(0, 0, 0, 1, 0, 1, "p0os_hold");
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "restart_from_done");
        nop(0, 1, 1, 0, 0, 1, "restart_tc");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "p0os_pause");
        nop(0, 0, 0, 0, 0, 1, "p0os_gap");
        cmd(OP_STOP, 0, 0, 0, 0, 0, 0, 0, 0, "p0os_idle");
        nop(0, 0, 0, 0, 0, 1, "p0os_gap2");

        // Maximum period counts all the way up without wrapping early
        cmd(OP_LOAD, 4'd15, 0, 0, 0, 0, 0, 0, 0, "max_load");
        nop(0, 0, 0, 0, 0, 1, "max_gap");
        cmd(OP_START, 0, 0, 0, 1, 0, 0, 0, 0, "max_start");
        for (int i = 1; i <= 15; i++) nop(W'(i), 1, 0, 0, 0, 1, "max_run");
        nop(15, 0, 1, 1, 0, 1, "max_done");
        cmd(OP_LOAD, 4'd9, 0, 0, 0, 0, 0, 0, 0, "max_clear");
        nop(0, 0, 0, 0, 0, 1, "max_gap2");

        // Reset mid-RUN: rst_seq's first edge takes count to 7, reset follows
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "mr_start");
        for (int i = 1; i <= 6; i++) nop(W'(i), 1, 0, 0, 0, 1, "mr_run");
        rst_seq();
        nop(0, 0, 0, 0, 0, 1, "mr_release");
        cmd(OP_START, 0, 0, 0, 1, 0, 0, 0, 0, "mr_start_p0");
        nop(0, 0, 1, 1, 0, 1, "mr_period_cleared");

`ifdef PRESCALER_EN
        // Prescale 2, period 1, auto-reload: count steps every 3 cycles, tc every 6
        prescale = 4'd2;
        cmd(OP_LOAD, 4'd1, 0, 0, 0, 0, 0, 0, 0, "ps_load");
        nop(0, 0, 0, 0, 0, 1, "ps_gap");
        cmd(OP_START, 0, 1, 0, 1, 0, 0, 0, 0, "ps_start");
        for (int i = 1; i <= 12; i++) begin
            c = ((i % 6) >= 3) ? W'(1) : W'(0);
            nop(c, 1, ((i % 6) == 0), 0, 0, 1, "ps_run");
        end
        prescale = 4'd0;
`endif

        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Command-driven controller that sequences an up-counter datapath as a programmable interval timer.
- A requester loads a period over a valid/ready command port, then starts, pauses, resumes or stops the count.
- Supports one-shot and auto-reload operation, and reports terminal-count events to downstream logic.
- Sits between the system control logic and the counter datapath; the count register is internal and exported on count.

Parameters:
WIDTH, 4, width of count and period registers
PRE_W, 4, prescaler width (used only with PRESCALER_EN)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 NOP, 01 START, 10 STOP, 11 LOAD
cmd_data  input  WIDTH  period value for LOAD
cmd_mode  input  1  0 one-shot, 1 auto-reload; sampled on START from IDLE/DONE
count  output  WIDTH  current count value
busy  output  1  high in RUN
tc  output  1  one-cycle terminal-count pulse
done  output  1  level; one-shot completed
err  output  1  one-cycle pulse; illegal command discarded

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: state=IDLE, count=0, period=0, mode=0, busy=0, tc=0, done=0, err=0, cmd_ready=0. cmd_ready rises on the first clk edge after rst deasserts.
- Reset mid-operation aborts immediately. No command or event survives it.
- Handshake: a command is accepted at an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready goes low for exactly one cycle after each accepted command, then returns high.
  - NOP is accepted with no effect.
- States: IDLE, RUN, PAUSED, DONE. All outputs are registered.
- LOAD:
  - IDLE/PAUSED/DONE: period<=cmd_data. State is unchanged, except DONE->IDLE with done cleared and count cleared.
  - RUN: discarded, err=1 for one cycle.
- START:
  - IDLE/DONE: state->RUN, count<=0, mode<=cmd_mode, done<=0.
  - PAUSED: state->RUN; count is kept and mode is unchanged.
  - RUN: discarded, err=1.
- STOP:
  - RUN: state->PAUSED; count holds.
  - PAUSED/IDLE/DONE: state->IDLE, count<=0, done<=0.
- RUN counting (no command accepted this edge):
  - count!=period: count<=count+1.
  - count==period, auto-reload: count<=0, tc=1 next cycle. tc therefore pulses every period+1 cycles.
  - count==period, one-shot: state->DONE, count holds period, done<=1, tc=1 next cycle.
- Latency: START accepted at edge N gives count=0, busy=1 after N, and count=1 after N+1.
- Boundaries:
  - period=0 in auto-reload gives tc every cycle from edge N+1 on.
  - period=0 in one-shot goes to DONE at edge N+1.
  - period=2^WIDTH-1 never wraps through the count==period check.
- Simultaneous events: an accepted command at the same edge as a terminal condition takes priority. The terminal event is suppressed (no tc, no done). Example: STOP at count==period gives PAUSED with count=period.
- tc and err are single-cycle pulses and are never high in IDLE or PAUSED except the cycle directly following the causing edge.

Optional Feature:
PRESCALER_EN
- Defined:
  - Adds input prescale [PRE_W-1:0].
  - An internal prescaler counter gates counting: count advances, or the terminal check fires, only on edges where the prescaler equals prescale. The prescaler then wraps to 0; otherwise it increments.
  - The prescaler clears on reset, on START from IDLE/DONE, and on STOP to IDLE. It holds in PAUSED and DONE.
  - prescale=0 behaves identically to the undefined build.
- Undefined: no prescale port and no prescaler logic; count advances every clk cycle in RUN.

Test Plan:
- Reset: rst=0 mid-RUN with count=7 -> same cycle count=0, busy=0, done=0, cmd_ready=0; cmd_ready=1 one edge after rst=1.
- Auto-reload: LOAD 3, START mode=1 -> count sequence 0,1,2,3,0,1..., tc pulses every 4 cycles; 3 pulses in 12 cycles after the first count=0.
- One-shot: LOAD 5, START mode=0 -> count 0..5, then DONE with count=5, done=1, single tc pulse, busy=0; later LOAD 2 -> IDLE, count=0, done=0.
- Pause/resume: LOAD 9, START, STOP at count=4 -> PAUSED, count holds 4 for 10 cycles; START -> continues 5,6...; STOP twice -> IDLE, count=0.
- Illegal/simultaneous: LOAD 1 during RUN -> err pulse, period unchanged; STOP accepted at count==period -> no tc, state PAUSED; back-to-back cmd_valid -> every second cycle accepted (cmd_ready 1-cycle low).
- PRESCALER_EN: prescale=2, LOAD 1, START mode=1 -> count changes every 3 cycles, tc every 6 cycles.
